// File: rtl/seg_display_pkg.sv
// seg_display_pkg
//   Shared constants and helpers for the 7-segment display multiplexer.
//   SEG_TABLE : active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0-F
//   SEG_OFF   : all segments dark
//   anode_n   : one bit of the one-hot active-low anode pattern
package seg_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index = nibble value; A,b,C,d,E,F drawn in mixed case.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit 'pos' of the active-low anode pattern selecting digit 'idx':
    // low only at the selected position.
    function automatic logic anode_n(input logic [3:0] idx, input logic [3:0] pos);
        return idx != pos;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec
//   Combinational hex nibble to active-low 7-segment decoder.
//   nibble : 4-bit hex value
//   sseg   : segments {g,f,e,d,c,b,a}, active-low
module hex7seg_dec
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] sseg
);

    always_comb begin
        sseg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux
//   Time-multiplexed driver for a common-anode 7-segment bank. One digit is
//   scanned per refresh slot; data/blank/dp are double-buffered and committed
//   only at frame boundaries so a frame never mixes old and new values.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : 1-cycle strobe capturing data/blank/dp into the pending buffer
//   data          : hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   blank, dp     : per-digit force-dark and decimal point enables
//   lz_en         : leading-zero suppression (live)
//   brightness    : PWM level, 0 = 1/16 duty, 15 = full (live)
//   an            : anode enables, active-low
//   sseg, dp_n    : segments and decimal point, active-low
//   frame_tick    : 1-cycle pulse as the digit index wraps to 0
module seg_display_mux
    import seg_display_pkg::*;
#(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned DIV_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  lz_en,
    input  logic [3:0]            brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            sseg,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic [DIV_LOG2-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     pend_q, pend_d;
    logic [N_DIGITS-1:0][3:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [N_DIGITS-1:0]      pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic [N_DIGITS-1:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]      an_q, an_d;
    logic [6:0]               sseg_q, sseg_d;
    logic                     dp_n_q, dp_n_d;
    logic                     frame_tick_q;

    logic                     slot_end, frame_end;
    logic [N_DIGITS-1:0]      supp;
    logic [3:0]               cur_nibble;
    logic [6:0]               dec_sseg;
    logic                     cur_blank, cur_dp, cur_supp, pwm_on;
    logic [N_DIGITS-1:0]      an_sel;

    // Scan counters and double buffer.
    always_comb begin
        slot_end  = &cnt_q;
        frame_end = slot_end && (idx_q == LAST_IDX);
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;

        if (load) begin
            pend_d       = 1'b1;
            pend_data_d  = data;
            pend_blank_d = blank;
            pend_dp_d    = dp;
        end
        // Commit from the *_d side so a load on the boundary cycle goes straight through.
        if (frame_end && (pend_q || load)) begin
            act_data_d  = pend_data_d;
            act_blank_d = pend_blank_d;
            act_dp_d    = pend_dp_d;
            pend_d      = 1'b0;
        end
    end

    // Leading-zero mask: a digit is suppressed while everything from the top
    // down to it is zero (blanked digits count as zero). Digit 0 never is.
    always_comb begin : lz_mask
        logic seen_nz;
        seen_nz = 1'b0;
        supp    = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (!act_blank_q[i] && (act_data_q[i] != 4'h0)) begin
                seen_nz = 1'b1;
            end
            supp[i] = lz_en && !seen_nz;
        end
    end

    hex7seg_dec u_dec (
        .nibble (cur_nibble),
        .sseg   (dec_sseg)
    );

    always_comb begin
        cur_nibble = act_data_q[idx_q];
        cur_blank  = act_blank_q[idx_q];
        cur_dp     = act_dp_q[idx_q];
        cur_supp   = supp[idx_q];
        pwm_on     = cnt_q[DIV_LOG2-1 -: 4] <= brightness;

        for (int i = 0; i < N_DIGITS; i++) begin
            an_sel[i] = anode_n(4'(idx_q), 4'(i));
        end

        // A suppressed digit still lights its anode when it carries a decimal point.
        an_d = '1;
        if (pwm_on && !cur_blank && (!cur_supp || cur_dp)) begin
            an_d = an_sel;
        end
        sseg_d = (cur_blank || cur_supp) ? SEG_OFF : dec_sseg;
        dp_n_d = cur_blank || !cur_dp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_blank_q <= '1;
            pend_dp_q    <= '0;
            act_data_q   <= '0;
            act_blank_q  <= '1;
            act_dp_q     <= '0;
            an_q         <= '1;
            sseg_q       <= SEG_OFF;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_end;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux
//   Self-checking bench for seg_display_mux with N_DIGITS=8, DIV_LOG2=4.
//   The reference model derives every output from the number of clocks since
//   reset (slot = 16 clks, frame = 128 clks) and a simple buffer record.
module tb_seg_display_mux;

    logic        clk, rst, load, lz_en, dp_n, frame_tick;
    logic [31:0] data;
    logic [7:0]  blank, dp, an;
    logic [3:0]  brightness;
    logic [6:0]  sseg;

    seg_display_mux #(
        .N_DIGITS (8),
        .DIV_LOG2 (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .blank      (blank),
        .dp         (dp),
        .lz_en      (lz_en),
        .brightness (brightness),
        .an         (an),
        .sseg       (sseg),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model state
    int          k;
    logic [31:0] m_data, m_pdata;
    logic [7:0]  m_blank, m_pblank, m_dp, m_pdp;
    logic        m_flag;
    logic [16:0] want, got;
    localparam logic [16:0] DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};

    task automatic model_reset();
        k = 0;
        m_data = '0; m_pdata = '0;
        m_blank = '1; m_pblank = '1;
        m_dp = '0; m_pdp = '0;
        m_flag = 1'b0;
        want = DARK;
    endtask

    // Advance one clock (called at a negedge); want becomes the outputs expected afterwards.
    task automatic tick();
        int         ph, d, msd;
        logic       supp, tk_e, dpn_e;
        logic [7:0] an_e;
        logic [6:0] sg_e;
        logic [3:0] nib;
        ph  = k % 16;
        d   = (k / 16) % 8;
        msd = 0;
        for (int i = 0; i < 8; i++) begin
            if (!m_blank[i] && m_data[4*i +: 4] != 4'h0) msd = i;
        end
        supp  = lz_en && (d > msd);
        nib   = m_data[4*d +: 4];
        an_e  = (ph <= int'(brightness) && !m_blank[d] && (!supp || m_dp[d])) ?
                ~(8'd1 << d) : 8'hFF;
        sg_e  = (m_blank[d] || supp) ? 7'h7F : hex_tab[nib];
        dpn_e = m_blank[d] ? 1'b1 : ~m_dp[d];
        tk_e  = (k % 128) == 127;
        if (load) begin
            m_pdata = data; m_pblank = blank; m_pdp = dp; m_flag = 1'b1;
        end
        if (tk_e && m_flag) begin
            m_data = m_pdata; m_blank = m_pblank; m_dp = m_pdp; m_flag = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        k++;
        want = {an_e, sg_e, dpn_e, tk_e};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got = {an, sseg, dp_n, frame_tick};
        checks++;
        if (got !== DARK) begin
            errors++; $display("FAIL reset_value: got %h, want %h", got, DARK);
        end
        model_reset();
        rst = 1'b0;
        repeat (384) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL reset_dark k=%0d: got %h, want %h", k, got, want);
            end
        end
    endtask

    task automatic test_basic();
        int n_fe, n_fd;
        brightness = 4'd15; lz_en = 1'b0;
        data = 32'h12345678; blank = '0; dp = '0; load = 1'b1;
        tick();
        load = 1'b0;
        do begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL basic_wait k=%0d: got %h, want %h", k, got, want);
            end
        end while (k % 128 != 0);
        n_fe = 0; n_fd = 0;
        repeat (128) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL basic_frame k=%0d: got %h, want %h", k, got, want);
            end
            if (an === 8'hFE && sseg === 7'h00) n_fe++;
            if (an === 8'hFD && sseg === 7'h78) n_fd++;
        end
        checks++;
        if (n_fe !== 16) begin errors++; $display("FAIL basic_digit0: got %0d clks, want 16", n_fe); end
        checks++;
        if (n_fd !== 16) begin errors++; $display("FAIL basic_digit1: got %0d clks, want 16", n_fd); end
    endtask

    task automatic test_lz();
        int n_a, n_b;
        lz_en = 1'b1; brightness = 4'd15; blank = '0;
        for (int c = 0; c < 3; c++) begin
            data = (c == 0) ? 32'h00000A05 : ((c == 1) ? 32'h0 : 32'h5);
            dp   = (c == 2) ? 8'h40 : 8'h00;
            load = 1'b1;
            tick();
            load = 1'b0;
            do begin
                tick();
                got = {an, sseg, dp_n, frame_tick};
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL lz_wait c=%0d k=%0d: got %h, want %h", c, k, got, want);
                end
            end while (k % 128 != 0);
            n_a = 0; n_b = 0;
            repeat (128) begin
                tick();
                got = {an, sseg, dp_n, frame_tick};
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL lz_frame c=%0d k=%0d: got %h, want %h", c, k, got, want);
                end
                case (c)
                    0: begin
                        if (an[7:3] !== 5'h1F) n_a++;
                        if (an === 8'hFD && sseg === 7'h40) n_b++;
                    end
                    1: begin
                        if (an !== 8'hFF && an !== 8'hFE) n_a++;
                        if (an === 8'hFE && sseg === 7'h40) n_b++;
                    end
                    default: begin
                        if (an !== 8'hFF && an !== 8'hFE && an !== 8'hBF) n_a++;
                        if (an === 8'hBF && sseg === 7'h7F && dp_n === 1'b0) n_b++;
                    end
                endcase
            end
            checks++;
            if (n_a !== 0) begin errors++; $display("FAIL lz_dark c=%0d: got %0d, want 0", c, n_a); end
            checks++;
            if (n_b !== 16) begin errors++; $display("FAIL lz_lit c=%0d: got %0d, want 16", c, n_b); end
        end
        lz_en = 1'b0; dp = '0;
    endtask

    task automatic test_pwm();
        int lit;
        logic [3:0] levels [3];
        levels[0] = 4'd3; levels[1] = 4'd0; levels[2] = 4'($urandom_range(15));
        brightness = 4'd15; lz_en = 1'b0;
        data = 32'h98765432; blank = '0; dp = '0; load = 1'b1;
        tick();
        load = 1'b0;
        do begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL pwm_wait k=%0d: got %h, want %h", k, got, want);
            end
        end while (k % 128 != 0);
        for (int j = 0; j < 3; j++) begin
            brightness = levels[j];
            lit = 0;
            repeat (128) begin
                tick();
                got = {an, sseg, dp_n, frame_tick};
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL pwm_cycle b=%0d k=%0d: got %h, want %h", brightness, k, got, want);
                end
                if (an !== 8'hFF) lit++;
            end
            checks++;
            if (lit !== 8 * (int'(levels[j]) + 1)) begin
                errors++;
                $display("FAIL pwm_duty b=%0d: got %0d lit clks, want %0d", levels[j], lit, 8 * (int'(levels[j]) + 1));
            end
        end
    endtask

    task automatic test_double_buffer();
        int n_one;
        brightness = 4'd15; lz_en = 1'b0; blank = '0; dp = '0;
        // Mid-frame load must not show before the wrap.
        while (k % 128 != 40) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL db_a k=%0d: got %h, want %h", k, got, want); end
        end
        data = 32'h11111111; load = 1'b1;
        n_one = 0;
        do begin
            tick();
            load = 1'b0;
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL db_b k=%0d: got %h, want %h", k, got, want); end
            if (sseg === 7'h79) n_one++;
        end while (k % 128 != 0);
        checks++;
        if (n_one !== 0) begin errors++; $display("FAIL db_tear: got %0d early clks, want 0", n_one); end
        tick();
        checks++;
        if ({an, sseg} !== {8'hFE, 7'h79}) begin
            errors++; $display("FAIL db_commit: got %h/%h, want fe/79", an, sseg);
        end
        // Load on the boundary cycle itself.
        while (k % 128 != 127) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL db_c k=%0d: got %h, want %h", k, got, want); end
        end
        data = 32'h33333333; load = 1'b1;
        tick();
        load = 1'b0;
        got = {an, sseg, dp_n, frame_tick};
        checks++;
        if (got !== want) begin errors++; $display("FAIL db_bound k=%0d: got %h, want %h", k, got, want); end
        tick();
        checks++;
        if (sseg !== 7'h30) begin errors++; $display("FAIL db_bound_show: got %h, want 30", sseg); end
        // Two loads in one frame: only the second survives.
        while (k % 128 != 10) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL db_d k=%0d: got %h, want %h", k, got, want); end
        end
        data = 32'h44444444; load = 1'b1;
        tick();
        load = 1'b0;
        while (k % 128 != 60) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL db_e k=%0d: got %h, want %h", k, got, want); end
        end
        data = 32'h55555555; load = 1'b1;
        tick();
        load = 1'b0;
        while (k % 128 != 0) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL db_f k=%0d: got %h, want %h", k, got, want); end
        end
        tick();
        checks++;
        if (sseg !== 7'h12) begin errors++; $display("FAIL db_second_load: got %h, want 12", sseg); end
    endtask

    task automatic test_random();
        int nd;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(19) == 0) begin
                nd    = $urandom_range(8);
                data  = (nd == 0) ? 32'h0 : ($urandom & (32'hFFFFFFFF >> (4 * (8 - nd))));
                blank = 8'($urandom) & 8'($urandom) & 8'($urandom);
                dp    = 8'($urandom);
                load  = 1'b1;
            end
            if ($urandom_range(49) == 0) brightness = 4'($urandom_range(15));
            if ($urandom_range(99) == 0) lz_en = ~lz_en;
            tick();
            load = 1'b0;
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL random k=%0d: got %h, want %h", k, got, want); end
        end
    endtask

    task automatic test_reset_mid();
        brightness = 4'd15; lz_en = 1'b0; blank = '0; dp = '0;
        data = 32'h76543210; load = 1'b1;
        tick();
        load = 1'b0;
        do begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL rmid_a k=%0d: got %h, want %h", k, got, want); end
        end while (k % 128 != 0);
        repeat (5) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL rmid_b k=%0d: got %h, want %h", k, got, want); end
        end
        data = 32'hFFFFFFFF; load = 1'b1;
        tick();
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        got = {an, sseg, dp_n, frame_tick};
        checks++;
        if (got !== DARK) begin errors++; $display("FAIL rmid_async: got %h, want %h", got, DARK); end
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        repeat (384) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL rmid_lost k=%0d: got %h, want %h", k, got, want); end
        end
        data = 32'h00000009; load = 1'b1;
        tick();
        load = 1'b0;
        while (k % 128 != 0) begin
            tick();
            got = {an, sseg, dp_n, frame_tick};
            checks++;
            if (got !== want) begin errors++; $display("FAIL rmid_c k=%0d: got %h, want %h", k, got, want); end
        end
        tick();
        checks++;
        if ({an, sseg} !== {8'hFE, 7'h10}) begin
            errors++; $display("FAIL rmid_restart: got %h/%h, want fe/10", an, sseg);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = '0; blank = '0; dp = '0;
        lz_en = 1'b0; brightness = 4'd15;
        model_reset();
        test_reset();
        test_basic();
        test_lz();
        test_pwm();
        test_double_buffer();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
